// File: rtl/vm1_irq_sched_pkg.sv
// vm1_irq_sched_pkg: shared FSM state encodings, bus-request levels and level helper for the IRQ scheduler
package vm1_irq_sched_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [2:0] LVL_OFS = 3'd4;
    localparam logic [2:0] LVL_BR4 = LVL_OFS;
    localparam logic [2:0] LVL_BR5 = LVL_OFS + 3'd1;
    localparam logic [2:0] LVL_BR6 = LVL_OFS + 3'd2;
    localparam logic [2:0] LVL_BR7 = LVL_OFS + 3'd3;

    function automatic logic [2:0] br_level(input logic [1:0] p);
        return p == 2'd3 ? LVL_BR7 : p == 2'd2 ? LVL_BR6 : p == 2'd1 ? LVL_BR5 : LVL_BR4;
    endfunction

endpackage

// File: rtl/vm1_irq_pick.sv
// vm1_irq_pick: combinational winner select (highest level, then round-robin with IRQ_RR_EN or lowest index)
//  elig    in   N    eligible sources
//  rr      in   IW   round-robin start index (present only with IRQ_RR_EN)
//  win_oh  out  N    one-hot winner, zero when nothing is eligible
//  win_idx out  IW   binary winner index
module vm1_irq_pick
    import vm1_irq_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int IW = 2,
    parameter logic [2*N-1:0] PRI = '0
) (
    input  logic [N-1:0]  elig,
`ifdef IRQ_RR_EN
    input  logic [IW-1:0] rr,
`endif
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx
);

    logic [2:0]   top_lvl;
    logic [N-1:0] top;
`ifdef IRQ_RR_EN
    logic [IW-1:0] j;
`endif

    always_comb begin
        top_lvl = '0;
        top = '0;
        for (int i = 0; i < N; i++)
            if (elig[i] && br_level(PRI[2*i+:2]) > top_lvl) top_lvl = br_level(PRI[2*i+:2]);
        for (int i = 0; i < N; i++)
            top[i] = elig[i] && br_level(PRI[2*i+:2]) == top_lvl;
    end

    // Scan backwards so the last hit is the closest candidate to the start point.
    always_comb begin
        win_idx = '0;
        win_oh = '0;
`ifdef IRQ_RR_EN
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(rr) + k) % N);
            if (top[j]) win_idx = j;
        end
`else
        for (int i = N - 1; i >= 0; i--)
            if (top[i]) win_idx = IW'(i);
`endif
        win_oh[win_idx] = |top;
    end

endmodule

// File: rtl/vm1_irq_sched.sv
// vm1_irq_sched: interrupt request scheduler presenting one held one-hot request to the VIC (IRQ_RR_EN selects round-robin ties)
//  clk_sys   in   1   system clock
//  wb_rst_i  in   1   asynchronous active-high reset
//  ce        in   1   clock enable, all state advances only when high
//  src_req   in   N   peripheral requests
//  src_ack   out  N   acknowledge pulse to the granted source
//  cpu_pri   in   3   CPU priority
//  vic_ireq  out  N   one-hot or zero request to the VIC
//  vic_iack  in   N   VIC per-source acknowledge
//  pend_o    out  N   pending status
//  tmo_o     out  1   grant timeout pulse
module vm1_irq_sched
    import vm1_irq_sched_pkg::*;
#(
    parameter int N = 4,
    parameter logic [2*N-1:0] PRI = '0,
    parameter logic [N-1:0] EDGE = '0,
    parameter int TMO_W = 8
) (
    input  logic         clk_sys,
    input  logic         wb_rst_i,
    input  logic         ce,
    input  logic [N-1:0] src_req,
    output logic [N-1:0] src_ack,
    input  logic [2:0]   cpu_pri,
    output logic [N-1:0] vic_ireq,
    input  logic [N-1:0] vic_iack,
    output logic [N-1:0] pend_o,
    output logic         tmo_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req_q;
    logic [N-1:0]     edge_lat;
    logic [N-1:0]     pend;
    logic [N-1:0]     elig;
    logic [N-1:0]     win_oh;
    logic [IW-1:0]    win_idx;
    logic [1:0]       state;
    logic [IW-1:0]    w;
    logic [TMO_W-1:0] timer;

    assign pend = (EDGE & edge_lat) | (~EDGE & src_req);
    // Level requests pass straight through, so gate them to honour zero outputs during reset.
    assign pend_o = pend & ~{N{wb_rst_i}};

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++)
            elig[i] = pend[i] && br_level(PRI[2*i+:2]) > cpu_pri;
    end

`ifdef IRQ_RR_EN
    logic [IW-1:0] rr;
    always_ff @(posedge clk_sys or posedge wb_rst_i) begin
        if (wb_rst_i) rr <= '0;
        else if (ce && state == ST_GRANT && vic_iack[w]) rr <= (w == IW'(N - 1)) ? '0 : w + 1'b1;
    end
`endif

    vm1_irq_pick #(.N(N), .IW(IW), .PRI(PRI)) u_pick (
        .elig(elig),
`ifdef IRQ_RR_EN
        .rr(rr),
`endif
        .win_oh(win_oh),
        .win_idx(win_idx)
    );

    always_ff @(posedge clk_sys or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            req_q <= '0;
            edge_lat <= '0;
            src_ack <= '0;
            tmo_o <= 1'b0;
            vic_ireq <= '0;
            state <= ST_IDLE;
            w <= '0;
            timer <= '0;
        end else if (ce) begin
            req_q <= src_req;
            // Set dominates clear so an edge coinciding with an acknowledge is kept.
            edge_lat <= EDGE & ((src_req & ~req_q) | (edge_lat & ~vic_iack));
            src_ack <= '0;
            tmo_o <= 1'b0;
            case (state)
                ST_IDLE: if (|elig) begin
                    state <= ST_GRANT;
                    w <= win_idx;
                    vic_ireq <= win_oh;
                    timer <= '0;
                end
                ST_GRANT: if (vic_iack[w]) begin
                    src_ack <= vic_ireq;
                    vic_ireq <= '0;
                    state <= ST_RELEASE;
                end else if (!EDGE[w] && !src_req[w]) begin
                    vic_ireq <= '0;
                    state <= ST_RELEASE;
                end else if (&timer) begin
                    tmo_o <= 1'b1;
                    vic_ireq <= '0;
                    state <= ST_RELEASE;
                end else begin
                    timer <= timer + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vm1_irq_sched.sv
// tb_vm1_irq_sched: directed self-checking bench for vm1_irq_sched
module tb_vm1_irq_sched;

    logic       clk_sys = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       ce = 1'b1;
    logic [3:0] src_req = '0;
    logic [3:0] src_ack;
    logic [2:0] cpu_pri = '0;
    logic [3:0] vic_ireq;
    logic [3:0] vic_iack = '0;
    logic [3:0] pend_o;
    logic       tmo_o;

    logic [3:0] src_req_b = '0;
    logic [3:0] src_ack_b;
    logic [2:0] cpu_pri_b = '0;
    logic [3:0] vic_ireq_b;
    logic [3:0] vic_iack_b = '0;
    logic [3:0] pend_b;
    logic       tmo_b;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    // src0 BR4 edge, src1 BR5 level, src2 BR7 edge, src3 BR6 level
    vm1_irq_sched #(.N(4), .PRI(8'b10_11_01_00), .EDGE(4'b0101), .TMO_W(3)) dut (
        .clk_sys(clk_sys), .wb_rst_i(wb_rst_i), .ce(ce), .src_req(src_req), .src_ack(src_ack),
        .cpu_pri(cpu_pri), .vic_ireq(vic_ireq), .vic_iack(vic_iack), .pend_o(pend_o), .tmo_o(tmo_o)
    );

    // src0 and src3 both BR6 level
    vm1_irq_sched #(.N(4), .PRI(8'b10_00_00_10), .EDGE(4'b0000), .TMO_W(8)) dut_b (
        .clk_sys(clk_sys), .wb_rst_i(wb_rst_i), .ce(ce), .src_req(src_req_b), .src_ack(src_ack_b),
        .cpu_pri(cpu_pri_b), .vic_ireq(vic_ireq_b), .vic_iack(vic_iack_b), .pend_o(pend_b), .tmo_o(tmo_b)
    );

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if (vic_ireq !== 4'b0) begin failures++; $display("FAIL rst_ireq got=%b exp=0000", vic_ireq); end
        checks++; if (src_ack !== 4'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0000", src_ack); end
        checks++; if (pend_o !== 4'b0 || tmo_o !== 1'b0) begin failures++; $display("FAIL rst_pend_tmo got=%b/%b exp=0000/0", pend_o, tmo_o); end
        checks++; if (vic_ireq_b !== 4'b0) begin failures++; $display("FAIL rst_ireq_b got=%b exp=0000", vic_ireq_b); end
        wb_rst_i = 1'b0;
        tick;
    endtask

    task automatic test_edge_grant;
        cpu_pri = 3'd3;
        src_req[0] = 1'b1;
        tick;
        checks++; if (pend_o !== 4'b0001 || vic_ireq !== 4'b0) begin failures++; $display("FAIL e_pend got=%b/%b exp=0001/0000", pend_o, vic_ireq); end
        tick;
        checks++; if (vic_ireq !== 4'b0001) begin failures++; $display("FAIL e_grant got=%b exp=0001", vic_ireq); end
        src_req[0] = 1'b0;
        vic_iack = 4'b0001;
        tick;
        vic_iack = 4'b0;
        checks++; if (src_ack !== 4'b0001 || pend_o !== 4'b0 || vic_ireq !== 4'b0) begin failures++; $display("FAIL e_ack got=%b/%b/%b exp=0001/0000/0000", src_ack, pend_o, vic_ireq); end
        tick;
        checks++; if (src_ack !== 4'b0 || vic_ireq !== 4'b0) begin failures++; $display("FAIL e_release got=%b/%b exp=0000/0000", src_ack, vic_ireq); end
        tick;
        checks++; if (vic_ireq !== 4'b0) begin failures++; $display("FAIL e_idle got=%b exp=0000", vic_ireq); end
    endtask

    task automatic test_priority;
        cpu_pri = 3'd5;
        src_req[1] = 1'b1;
        src_req[2] = 1'b1;
        tick; tick;
        checks++; if (vic_ireq !== 4'b0100) begin failures++; $display("FAIL p5_first got=%b exp=0100", vic_ireq); end
        src_req[2] = 1'b0;
        vic_iack = 4'b0100;
        tick;
        vic_iack = 4'b0;
        checks++; if (src_ack !== 4'b0100) begin failures++; $display("FAIL p5_ack got=%b exp=0100", src_ack); end
        tick; tick; tick;
        checks++; if (vic_ireq !== 4'b0) begin failures++; $display("FAIL p5_masked got=%b exp=0000", vic_ireq); end
        cpu_pri = 3'd6;
        src_req[2] = 1'b1;
        tick; tick;
        checks++; if (vic_ireq !== 4'b0100) begin failures++; $display("FAIL p6_grant got=%b exp=0100", vic_ireq); end
        src_req[2] = 1'b0;
        vic_iack = 4'b0100;
        tick;
        vic_iack = 4'b0;
        tick; tick; tick; tick;
        checks++; if (vic_ireq !== 4'b0 || pend_o !== 4'b0010) begin failures++; $display("FAIL p6_masked got=%b/%b exp=0000/0010", vic_ireq, pend_o); end
        cpu_pri = 3'd4;
        tick;
        checks++; if (vic_ireq !== 4'b0010) begin failures++; $display("FAIL p4_low got=%b exp=0010", vic_ireq); end
        vic_iack = 4'b0010;
        tick;
        vic_iack = 4'b0;
        src_req[1] = 1'b0;
        checks++; if (src_ack !== 4'b0010) begin failures++; $display("FAIL p4_ack got=%b exp=0010", src_ack); end
        tick; tick; tick;
    endtask

    task automatic test_timeout;
        bit held = 1'b1;
        cpu_pri = 3'd0;
        src_req[3] = 1'b1;
        tick;
        checks++; if (vic_ireq !== 4'b1000) begin failures++; $display("FAIL t_grant got=%b exp=1000", vic_ireq); end
        for (int k = 1; k <= 7; k++) begin
            tick;
            if (vic_ireq !== 4'b1000 || tmo_o !== 1'b0) held = 1'b0;
        end
        checks++; if (!held) begin failures++; $display("FAIL t_hold got=%b/%b exp=1000/0", vic_ireq, tmo_o); end
        tick;
        checks++; if (tmo_o !== 1'b1 || vic_ireq !== 4'b0 || pend_o !== 4'b1000) begin failures++; $display("FAIL t_fire got=%b/%b/%b exp=1/0000/1000", tmo_o, vic_ireq, pend_o); end
        tick;
        checks++; if (tmo_o !== 1'b0 || vic_ireq !== 4'b0) begin failures++; $display("FAIL t_gap got=%b/%b exp=0/0000", tmo_o, vic_ireq); end
        tick;
        checks++; if (vic_ireq !== 4'b1000) begin failures++; $display("FAIL t_regrant got=%b exp=1000", vic_ireq); end
        src_req[3] = 1'b0;
        tick; tick; tick;
    endtask

    task automatic test_level_withdraw;
        cpu_pri = 3'd4;
        src_req[1] = 1'b1;
        tick;
        checks++; if (vic_ireq !== 4'b0010) begin failures++; $display("FAIL w_grant got=%b exp=0010", vic_ireq); end
        src_req[1] = 1'b0;
        tick;
        checks++; if (vic_ireq !== 4'b0 || src_ack !== 4'b0 || tmo_o !== 1'b0) begin failures++; $display("FAIL w_drop got=%b/%b/%b exp=0000/0000/0", vic_ireq, src_ack, tmo_o); end
        tick;
        checks++; if (src_ack !== 4'b0 || tmo_o !== 1'b0 || vic_ireq !== 4'b0) begin failures++; $display("FAIL w_quiet got=%b/%b/%b exp=0000/0/0000", src_ack, tmo_o, vic_ireq); end
        tick;
    endtask

    task automatic test_reset_mid_grant;
        cpu_pri = 3'd0;
        src_req[3] = 1'b1;
        tick;
        src_req[0] = 1'b1;
        tick;
        checks++; if (vic_ireq !== 4'b1000 || pend_o !== 4'b1001) begin failures++; $display("FAIL r_pre got=%b/%b exp=1000/1001", vic_ireq, pend_o); end
        #2 wb_rst_i = 1'b1;
        #1;
        checks++; if (vic_ireq !== 4'b0 || src_ack !== 4'b0 || pend_o !== 4'b0 || tmo_o !== 1'b0) begin failures++; $display("FAIL r_async got=%b/%b/%b/%b exp=0000/0000/0000/0", vic_ireq, src_ack, pend_o, tmo_o); end
        src_req = '0;
        tick;
        wb_rst_i = 1'b0;
        tick;
        checks++; if (vic_ireq !== 4'b0 || pend_o !== 4'b0) begin failures++; $display("FAIL r_after got=%b/%b exp=0000/0000", vic_ireq, pend_o); end
    endtask

    task automatic test_edge_vs_iack;
        cpu_pri = 3'd3;
        src_req[0] = 1'b1;
        tick; tick;
        checks++; if (vic_ireq !== 4'b0001) begin failures++; $display("FAIL x_grant got=%b exp=0001", vic_ireq); end
        src_req[0] = 1'b0;
        tick;
        src_req[0] = 1'b1;
        vic_iack = 4'b0001;
        tick;
        vic_iack = 4'b0;
        checks++; if (src_ack !== 4'b0001 || pend_o !== 4'b0001) begin failures++; $display("FAIL x_keep got=%b/%b exp=0001/0001", src_ack, pend_o); end
        tick; tick;
        checks++; if (vic_ireq !== 4'b0001) begin failures++; $display("FAIL x_regrant got=%b exp=0001", vic_ireq); end
        src_req[0] = 1'b0;
        vic_iack = 4'b0001;
        tick;
        vic_iack = 4'b0;
        tick; tick;
        checks++; if (pend_o !== 4'b0 || vic_ireq !== 4'b0) begin failures++; $display("FAIL x_clear got=%b/%b exp=0000/0000", pend_o, vic_ireq); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_oh [4];
`ifdef IRQ_RR_EN
        exp_oh = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`else
        exp_oh = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        cpu_pri_b = 3'd0;
        src_req_b = 4'b1001;
        for (int g = 0; g < 4; g++) begin
            int n = 0;
            while (vic_ireq_b === 4'b0 && n < 10) begin
                tick;
                n++;
            end
            checks++; if (vic_ireq_b !== exp_oh[g]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", g, vic_ireq_b, exp_oh[g]); end
            vic_iack_b = exp_oh[g];
            tick;
            vic_iack_b = 4'b0;
        end
        src_req_b = 4'b0;
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_edge_grant;
        test_priority;
        test_timeout;
        test_level_withdraw;
        test_reset_mid_grant;
        test_edge_vs_iack;
        test_round_robin;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
